// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants: result word width, result buffer
// depth and drop-counter sizing.
package fp_pkg;

   localparam int FP_WORD_W       = 36;
   localparam int FP_RESBUF_DEPTH = 4;
   localparam int FP_DROPCNT_W    = 8;

   localparam logic [FP_DROPCNT_W-1:0] FP_DROPCNT_MAX = '1;

endpackage : fp_pkg

// File: rtl/fp_result_buf_if.sv
// Result handshake bundle: pipeline strobe/data toward the buffer and the
// valid/ready delivery side toward the consumer.
interface fp_result_buf_if #(
   parameter int WIDTH = fp_pkg::FP_WORD_W
);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // master: the environment (pipeline + consumer); slave: the result buffer
   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data
   );

endinterface : fp_result_buf_if

// File: rtl/fp_resbuf_mem.sv
// DEPTH x WIDTH register array for the result buffer: one synchronous write
// port and one asynchronous read port.
module fp_resbuf_mem
   import fp_pkg::*;
#(
   parameter int WIDTH = FP_WORD_W,
   parameter int DEPTH = FP_RESBUF_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage is deliberately not reset; the control logic never exposes
   // an entry that has not been written since reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : fp_resbuf_mem

// File: rtl/fp_result_buf.sv
// Output-side result buffer for the FP multiplier: small FIFO with sticky
// overflow flag. Define FP_RESBUF_DROPCNT_EN to add the saturating drop_cnt port.
module fp_result_buf
   import fp_pkg::*;
#(
   parameter int WIDTH = FP_WORD_W,
   parameter int DEPTH = FP_RESBUF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   fp_result_buf_if.slave         bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   overflow,
   input  logic                   clr_ovf
`ifdef FP_RESBUF_DROPCNT_EN
   ,
   output logic [FP_DROPCNT_W-1:0] drop_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [WIDTH-1:0] head_data;
   logic             pop;
   logic             push;
   logic             drop;

   // All outputs decode from level/rd_ptr registers, never from in_valid or out_ready.
   assign full          = (level == LVL_W'(DEPTH));
   assign bus.out_valid = (level != '0);
   assign bus.out_data  = bus.out_valid ? head_data : '0;

   assign pop  = bus.out_valid & bus.out_ready;
   assign push = bus.in_valid & (~full | pop);
   assign drop = bus.in_valid & full & ~pop;

   fp_resbuf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (bus.in_data),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            level <= level + LVL_W'(1);
         end else if (pop && !push) begin
            level <= level - LVL_W'(1);
         end
      end
   end

   // A drop in the same cycle as clr_ovf leaves the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

`ifdef FP_RESBUF_DROPCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (clr_ovf) begin
         drop_cnt <= drop ? FP_DROPCNT_W'(1) : '0;
      end else if (drop && (drop_cnt != FP_DROPCNT_MAX)) begin
         drop_cnt <= drop_cnt + FP_DROPCNT_W'(1);
      end
   end
`endif

endmodule : fp_result_buf

// File: tb/tb_fp_result_buf.sv
// Directed self-checking bench for fp_result_buf (drop_cnt checks follow
// FP_RESBUF_DROPCNT_EN).
module tb_fp_result_buf;
   import fp_pkg::*;

   localparam int WIDTH = FP_WORD_W;
   localparam int DEPTH = FP_RESBUF_DEPTH;

   logic                   clk;
   logic                   rst;
   logic [$clog2(DEPTH):0] level;
   logic                   full;
   logic                   overflow;
   logic                   clr_ovf;
`ifdef FP_RESBUF_DROPCNT_EN
   logic [FP_DROPCNT_W-1:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fp_result_buf_if #(.WIDTH(WIDTH)) bus ();

   fp_result_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .level    (level),
      .full     (full),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
`ifdef FP_RESBUF_DROPCNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, " out_data"},  64'(bus.out_data),  64'd0);
      check({tag, " level"},     64'(level),         64'd0);
      check({tag, " full"},      64'(full),          64'd0);
      check({tag, " overflow"},  64'(overflow),      64'd0);
`ifdef FP_RESBUF_DROPCNT_EN
      check({tag, " drop_cnt"},  64'(drop_cnt),      64'd0);
`endif
   endtask

   logic [WIDTH-1:0] exp_head [6];

   initial begin
      rst           = 1'b1;
      clr_ovf       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // Single word with consumer ready: visible one cycle later, then drained.
      bus.in_valid  = 1'b1;
      bus.in_data   = 36'h1_2345_6789;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("single out_valid", 64'(bus.out_valid), 64'd1);
      check("single out_data",  64'(bus.out_data),  64'h1_2345_6789);
      check("single level",     64'(level),         64'd1);
      tick();
      check("single drained level", 64'(level),         64'd0);
      check("single drained valid", 64'(bus.out_valid), 64'd0);

      // Fill with consumer stalled; no bypass while empty.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 36'h1;
      #1;
      check("no bypass out_valid", 64'(bus.out_valid), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         bus.in_data = WIDTH'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      check("fill full",  64'(full),          64'd1);
      check("fill level", 64'(level),         64'd4);
      check("fill head",  64'(bus.out_data),  64'h1);

      // Push into full buffer with no pop: dropped, head unchanged.
      bus.in_valid = 1'b1;
      bus.in_data  = 36'h5;
      tick();
      bus.in_valid = 1'b0;
      check("drop overflow", 64'(overflow),     64'd1);
      check("drop level",    64'(level),        64'd4);
      check("drop head",     64'(bus.out_data), 64'h1);
`ifdef FP_RESBUF_DROPCNT_EN
      check("drop drop_cnt", 64'(drop_cnt), 64'd1);
`endif

      // Full with push+pop for 6 cycles: order 1,2,3,4,11,12 across the wrap.
      exp_head[0] = 36'h1;
      exp_head[1] = 36'h2;
      exp_head[2] = 36'h3;
      exp_head[3] = 36'h4;
      exp_head[4] = 36'h11;
      exp_head[5] = 36'h12;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_data = WIDTH'(36'h11 + i);
         check($sformatf("stream head[%0d]", i), 64'(bus.out_data), 64'(exp_head[i]));
         tick();
         check($sformatf("stream level[%0d]", i), 64'(level), 64'd4);
      end
      bus.in_valid = 1'b0;
      check("stream overflow held", 64'(overflow), 64'd1);
`ifdef FP_RESBUF_DROPCNT_EN
      check("stream no extra drop", 64'(drop_cnt), 64'd1);
`endif
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain head[%0d]", i), 64'(bus.out_data), 64'(36'h13 + i));
         tick();
      end
      check("drain level",     64'(level),         64'd0);
      check("drain out_data",  64'(bus.out_data),  64'd0);

      // Refill to full, then drop together with clr_ovf.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = WIDTH'(36'h21 + i);
         tick();
      end
      check("refill full", 64'(full), 64'd1);
`ifdef FP_RESBUF_DROPCNT_EN
      bus.in_data = 36'h99;
      for (int i = 0; i < 256; i++) begin
         tick();
      end
      check("drop_cnt saturates", 64'(drop_cnt), 64'd255);
`endif
      bus.in_data = 36'h25;
      clr_ovf     = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("drop+clr overflow", 64'(overflow),     64'd1);
      check("drop+clr head",     64'(bus.out_data), 64'h21);
`ifdef FP_RESBUF_DROPCNT_EN
      check("drop+clr drop_cnt", 64'(drop_cnt), 64'd1);
`endif
      tick();
      clr_ovf = 1'b0;
      check("clr overflow", 64'(overflow), 64'd0);
`ifdef FP_RESBUF_DROPCNT_EN
      check("clr drop_cnt", 64'(drop_cnt), 64'd0);
`endif

      // Set overflow again, pop to level 3, then reset asynchronously mid-cycle.
      bus.in_valid = 1'b1;
      bus.in_data  = 36'h26;
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pre-reset level",    64'(level),    64'd3);
      check("pre-reset overflow", 64'(overflow), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_idle_outputs("async reset");
      tick();
      rst = 1'b0;

      // First word after reset is the new one.
      bus.in_valid = 1'b1;
      bus.in_data  = 36'hA;
      tick();
      bus.in_valid = 1'b0;
      check("post-reset valid", 64'(bus.out_valid), 64'd1);
      check("post-reset data",  64'(bus.out_data),  64'hA);
      check("post-reset level", 64'(level),         64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fp_result_buf
